// File: rtl/mlp_layer_sequencer.sv
// Address and handshake sequencer for the two-layer MLP datapath.
// Walks layer 1 (neuron i over inputs j), then layer 2 (output k over hidden h).
module mlp_layer_sequencer #(
    parameter int N_IN   = 784,
    parameter int N_HID  = 200,
    parameter int N_OUT  = 10,
    parameter int W1_AW  = 18,
    parameter int IN_AW  = 10,
    parameter int W2_AW  = 12,
    parameter int HID_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [W1_AW-1:0]  w1_addr,
    output logic [IN_AW-1:0]  in_addr,
    output logic              mac1_start,
    input  logic              mac1_done,
    output logic              hid_wr_en,
    output logic [HID_AW-1:0] hid_wr_addr,
    output logic [W2_AW-1:0]  w2_addr,
    output logic [HID_AW-1:0] hid_rd_addr,
    output logic              mac2_start,
    input  logic              mac2_done,
    output logic [3:0]        out_idx,
    output logic              out_valid
);

    typedef enum logic [2:0] {
        IDLE, L1_RUN, L1_WAIT, L1_WB, L2_RUN, L2_WAIT, L2_WB, FIN
    } state_t;

    localparam logic [IN_AW-1:0]  J_LAST  = IN_AW'(N_IN - 1);
    localparam logic [HID_AW-1:0] I_LAST  = HID_AW'(N_HID - 1);
    localparam logic [HID_AW-1:0] H_LAST  = HID_AW'(N_HID - 1);
    localparam logic [3:0]        K_LAST  = 4'(N_OUT - 1);
    localparam logic [W1_AW-1:0]  W1_STEP = W1_AW'(N_IN);
    localparam logic [W2_AW-1:0]  W2_STEP = W2_AW'(N_HID);

    state_t              r_state;
    state_t              w_nextState;
    logic [IN_AW-1:0]    r_j;
    logic [HID_AW-1:0]   r_i;
    logic [HID_AW-1:0]   r_h;
    logic [3:0]          r_k;
    logic [W1_AW-1:0]    r_base1;
    logic [W2_AW-1:0]    r_base2;
    logic                w_jLast;
    logic                w_iLast;
    logic                w_hLast;
    logic                w_kLast;

    assign w_jLast = (r_j == J_LAST);
    assign w_iLast = (r_i == I_LAST);
    assign w_hLast = (r_h == H_LAST);
    assign w_kLast = (r_k == K_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FIN accepts start directly so a held start costs only the one done cycle
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        mac1_start  = 1'b0;
        mac2_start  = 1'b0;
        hid_wr_en   = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_nextState = L1_RUN;
            end
            L1_RUN: begin
                if (w_jLast) begin
                    mac1_start  = 1'b1;
                    w_nextState = L1_WAIT;
                end
            end
            L1_WAIT: begin
                if (mac1_done) w_nextState = L1_WB;
            end
            L1_WB: begin
                hid_wr_en   = 1'b1;
                w_nextState = w_iLast ? L2_RUN : L1_RUN;
            end
            L2_RUN: begin
                if (w_hLast) begin
                    mac2_start  = 1'b1;
                    w_nextState = L2_WAIT;
                end
            end
            L2_WAIT: begin
                if (mac2_done) w_nextState = L2_WB;
            end
            L2_WB: begin
                out_valid   = 1'b1;
                w_nextState = w_kLast ? FIN : L2_RUN;
            end
            FIN: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_nextState = start ? L1_RUN : IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Base registers step by one row per neuron so no multiplier is needed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_h     <= '0;
            r_base1 <= '0;
            r_base2 <= '0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_h     <= '0;
                    r_base1 <= '0;
                    r_base2 <= '0;
                end
                L1_RUN: begin
                    if (!w_jLast) r_j <= r_j + 1'b1;
                end
                L1_WB: begin
                    if (w_iLast) begin
                        r_k     <= '0;
                        r_h     <= '0;
                        r_base2 <= '0;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        r_j     <= '0;
                        r_base1 <= r_base1 + W1_STEP;
                    end
                end
                L2_RUN: begin
                    if (!w_hLast) r_h <= r_h + 1'b1;
                end
                L2_WB: begin
                    if (!w_kLast) begin
                        r_k     <= r_k + 1'b1;
                        r_h     <= '0;
                        r_base2 <= r_base2 + W2_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w1_addr     = r_base1 + W1_AW'(r_j);
    assign in_addr     = r_j;
    assign hid_wr_addr = r_i;
    assign w2_addr     = r_base2 + W2_AW'(r_h);
    assign hid_rd_addr = r_h;
    assign out_idx     = r_k;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer with a reduced network (8 -> 5 -> 6) and a
// mac responder; each run is compared cycle by cycle against a spec-derived trace.
module tb_mlp_layer_sequencer;

    localparam int N_IN  = 8;
    localparam int N_HID = 5;
    localparam int N_OUT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [17:0] w1_addr;
    logic [9:0]  in_addr;
    logic        mac1_start;
    logic        mac1_done;
    logic        hid_wr_en;
    logic [7:0]  hid_wr_addr;
    logic [11:0] w2_addr;
    logic [7:0]  hid_rd_addr;
    logic        mac2_start;
    logic        mac2_done;
    logic [3:0]  out_idx;
    logic        out_valid;

    logic resp1 = 1'b0;
    logic resp2 = 1'b0;
    logic spur1;
    logic spur2;

    assign mac1_done = resp1 | spur1;
    assign mac2_done = resp2 | spur2;

    int checks = 0;
    int errors = 0;
    int respW = 1;
    int resp2First = 1;
    int cnt1 = 0;
    int cnt2 = 0;
    int mac2Seen = 0;
    int stepCnt;
    int doneCyc;
    int traceErrs;
    int hweCnt;
    int ovCnt;
    string firstMsg;

    typedef struct {
        string name;
        int    w;
        int    w2First;
        bit    spur;
        bit    repulse;
        bit    hold;
        bit    already;
        int    expCycles;
    } runVec_t;

    runVec_t vecs[6];

    mlp_layer_sequencer #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .N_OUT (N_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .w1_addr     (w1_addr),
        .in_addr     (in_addr),
        .mac1_start  (mac1_start),
        .mac1_done   (mac1_done),
        .hid_wr_en   (hid_wr_en),
        .hid_wr_addr (hid_wr_addr),
        .w2_addr     (w2_addr),
        .hid_rd_addr (hid_rd_addr),
        .mac2_start  (mac2_start),
        .mac2_done   (mac2_done),
        .out_idx     (out_idx),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    // Returns each mac done W cycles after its start pulse; the first layer-2
    // output of a run may use a separate (long) delay.
    always begin
        @(posedge clk);
        #1;
        resp1 = 1'b0;
        resp2 = 1'b0;
        if (!busy) begin
            cnt1     = 0;
            cnt2     = 0;
            mac2Seen = 0;
        end else begin
            if (cnt1 > 0) begin
                cnt1--;
                if (cnt1 == 0) resp1 = 1'b1;
            end
            if (cnt2 > 0) begin
                cnt2--;
                if (cnt2 == 0) resp2 = 1'b1;
            end
            if (mac1_start) cnt1 = respW;
            if (mac2_start) begin
                cnt2 = (mac2Seen == 0) ? resp2First : respW;
                mac2Seen++;
            end
        end
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
        stepCnt++;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_busy"},        int'(busy),        0);
        checkVal({tag, "_done"},        int'(done),        0);
        checkVal({tag, "_mac1_start"},  int'(mac1_start),  0);
        checkVal({tag, "_mac2_start"},  int'(mac2_start),  0);
        checkVal({tag, "_hid_wr_en"},   int'(hid_wr_en),   0);
        checkVal({tag, "_out_valid"},   int'(out_valid),   0);
        checkVal({tag, "_w1_addr"},     int'(w1_addr),     0);
        checkVal({tag, "_in_addr"},     int'(in_addr),     0);
        checkVal({tag, "_w2_addr"},     int'(w2_addr),     0);
        checkVal({tag, "_hid_rd_addr"}, int'(hid_rd_addr), 0);
        checkVal({tag, "_hid_wr_addr"}, int'(hid_wr_addr), 0);
        checkVal({tag, "_out_idx"},     int'(out_idx),     0);
    endtask

    // ph: 1 = layer-1 addresses checked, 2 = layer-2 addresses checked, 0 = neither
    task automatic expectOut(input int ph, input int eW1, input int eIn, input bit eM1,
                             input bit eHwe, input int eHwa, input int eW2, input int eHrd,
                             input bit eM2, input bit eOv, input int eOi,
                             input bit eBusy, input bit eDone);
        logic [5:0] aCtl;
        logic [5:0] eCtl;
        bit bad;
        bad  = 1'b0;
        aCtl = {busy, done, mac1_start, mac2_start, hid_wr_en, out_valid};
        eCtl = {eBusy, eDone, eM1, eM2, eHwe, eOv};
        if (aCtl !== eCtl) bad = 1'b1;
        if (ph == 1 && (int'(w1_addr) != eW1 || int'(in_addr) != eIn)) bad = 1'b1;
        if (eHwe && int'(hid_wr_addr) != eHwa) bad = 1'b1;
        if (ph == 2 && (int'(w2_addr) != eW2 || int'(hid_rd_addr) != eHrd)) bad = 1'b1;
        if (eOv && int'(out_idx) != eOi) bad = 1'b1;
        if (done === 1'b1 && doneCyc < 0) doneCyc = stepCnt;
        if (hid_wr_en === 1'b1) hweCnt++;
        if (out_valid === 1'b1) ovCnt++;
        if (bad) begin
            traceErrs++;
            if (firstMsg == "")
                firstMsg = $sformatf("cycle %0d ctl got %b want %b w1 %0d/%0d in %0d/%0d w2 %0d/%0d hrd %0d/%0d hwa %0d/%0d idx %0d/%0d",
                                     stepCnt, aCtl, eCtl, w1_addr, eW1, in_addr, eIn, w2_addr, eW2,
                                     hid_rd_addr, eHrd, hid_wr_addr, eHwa, out_idx, eOi);
        end
    endtask

    task automatic runTrace(input runVec_t v);
        int waitLen;
        traceErrs  = 0;
        firstMsg   = "";
        doneCyc    = -1;
        hweCnt     = 0;
        ovCnt      = 0;
        respW      = v.w;
        resp2First = v.w2First;
        if (!v.already) begin
            start = 1'b1;
            stepClk();
        end
        stepCnt = 1;
        for (int i = 0; i < N_HID; i++) begin
            for (int j = 0; j < N_IN; j++) begin
                spur1 = 1'b0; spur2 = 1'b0; start = v.hold;
                if (v.spur && i == 0 && (j == 2 || j == N_IN - 1)) spur1 = 1'b1;
                if (v.spur && i == 1 && j == 3) spur2 = 1'b1;
                if (v.repulse && i == 0 && j == 4) start = 1'b1;
                expectOut(1, i * N_IN + j, j, j == N_IN - 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                stepClk();
            end
            for (int q = 0; q < v.w; q++) begin
                spur1 = 1'b0; spur2 = 1'b0; start = v.hold;
                expectOut(1, i * N_IN + N_IN - 1, N_IN - 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                stepClk();
            end
            spur1 = 1'b0; spur2 = 1'b0; start = v.hold;
            if (v.repulse && i == 2) start = 1'b1;
            expectOut(1, i * N_IN + N_IN - 1, N_IN - 1, 0, 1, i, 0, 0, 0, 0, 0, 1, 0);
            stepClk();
        end
        for (int k = 0; k < N_OUT; k++) begin
            for (int h = 0; h < N_HID; h++) begin
                spur1 = 1'b0; spur2 = 1'b0; start = v.hold;
                if (v.spur && k == 0 && h == 2) spur1 = 1'b1;
                if (v.spur && k == 1 && h == 1) spur2 = 1'b1;
                if (v.repulse && k == 1 && h == 0) start = 1'b1;
                expectOut(2, 0, 0, 0, 0, 0, k * N_HID + h, h, h == N_HID - 1, 0, 0, 1, 0);
                stepClk();
            end
            waitLen = (k == 0) ? v.w2First : v.w;
            for (int q = 0; q < waitLen; q++) begin
                spur1 = 1'b0; spur2 = 1'b0; start = v.hold;
                if (v.spur && k == 2 && q == 0) spur1 = 1'b1;
                expectOut(2, 0, 0, 0, 0, 0, k * N_HID + N_HID - 1, N_HID - 1, 0, 0, 0, 1, 0);
                stepClk();
            end
            spur1 = 1'b0; spur2 = 1'b0; start = v.hold;
            expectOut(2, 0, 0, 0, 0, 0, k * N_HID + N_HID - 1, N_HID - 1, 0, 1, k, 1, 0);
            stepClk();
        end
        spur1 = 1'b0; spur2 = 1'b0; start = v.hold;
        expectOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepClk();
        if (v.hold)
            expectOut(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        else
            expectOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (traceErrs != 0) begin
            errors++;
            $display("[TB] FAIL %s_trace: %0d bad cycles, expected 0; first at %s", v.name, traceErrs, firstMsg);
        end
        checkVal({v.name, "_doneCycle"}, doneCyc, v.expCycles);
        checkVal({v.name, "_hidWrites"}, hweCnt, N_HID);
        checkVal({v.name, "_outValids"}, ovCnt, N_OUT);
    endtask

    initial begin
        int found;
        int doneSeen;
        int busySeen;
        runVec_t restartVec;

        // cycles = N_HID*(N_IN+W+1) + N_OUT*(N_HID+W+1) + 1, extra stall added for mac2Stall
        vecs[0] = '{"w1",         1, 1,    1'b0, 1'b0, 1'b0, 1'b0, 93};
        vecs[1] = '{"w5",         5, 5,    1'b0, 1'b0, 1'b0, 1'b0, 137};
        vecs[2] = '{"spurious",   1, 1,    1'b1, 1'b1, 1'b0, 1'b0, 93};
        vecs[3] = '{"mac2Stall",  2, 1000, 1'b0, 1'b0, 1'b0, 1'b0, 1102};
        vecs[4] = '{"startHeld",  1, 1,    1'b0, 1'b0, 1'b1, 1'b0, 93};
        vecs[5] = '{"backToBack", 3, 3,    1'b0, 1'b0, 1'b0, 1'b1, 115};
        restartVec = '{"restart", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 93};

        reset = 1'b1;
        start = 1'b0;
        spur1 = 1'b0;
        spur2 = 1'b0;
        stepCnt = 0;
        repeat (3) stepClk();
        checkAllZero("reset");
        reset = 1'b0;
        stepClk();

        for (int n = 0; n < 6; n++) begin
            $display("[TB] run %s", vecs[n].name);
            runTrace(vecs[n]);
        end

        $display("[TB] abort during layer 2 at k=4");
        respW = 1;
        resp2First = 1;
        start = 1'b1;
        stepClk();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            if (mac2_start === 1'b1 && out_idx == 4'd4) found = 1;
            else stepClk();
        end
        checkVal("reachK4", found, 1);
        checkVal("busyBeforeAbort", int'(busy), 1);
        reset = 1'b1;
        stepClk();
        checkAllZero("abort");
        reset = 1'b0;
        doneSeen = 0;
        busySeen = 0;
        for (int n = 0; n < 10; n++) begin
            stepClk();
            if (done === 1'b1) doneSeen++;
            if (busy === 1'b1) busySeen++;
        end
        checkVal("noDoneAfterAbort", doneSeen, 0);
        checkVal("idleAfterAbort", busySeen, 0);
        runTrace(restartVec);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
